// File: rtl/sha1_pkg.sv
// Shared types, constants and round helpers for the single-block SHA-1 engine.
package sha1_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      ROUNDS,
      FINAL
   } state_t;

   localparam word_t IV [5] = '{
      32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0
   };

   localparam word_t K0 = 32'h5A827999;
   localparam word_t K1 = 32'h6ED9EBA1;
   localparam word_t K2 = 32'h8F1BBCDC;
   localparam word_t K3 = 32'hCA62C1D6;

   localparam logic [6:0] LAST_ROUND = 7'd79;

   function automatic word_t rotl(input word_t x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic word_t f_round(input logic [6:0] t, input word_t b,
                                     input word_t c, input word_t d);
      if (t < 7'd20)
         return (b & c) | (~b & d);
      else if (t < 7'd40)
         return b ^ c ^ d;
      else if (t < 7'd60)
         return (b & c) | (b & d) | (c & d);
      else
         return b ^ c ^ d;
   endfunction

   function automatic word_t k_round(input logic [6:0] t);
      if (t < 7'd20)
         return K0;
      else if (t < 7'd40)
         return K1;
      else if (t < 7'd60)
         return K2;
      else
         return K3;
   endfunction

endpackage

// File: rtl/sha1_msg_schedule.sv
// 16-word circular message schedule: loads the block on start, yields W_t each round.
module sha1_msg_schedule
   import sha1_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic       advance,
   input  logic [6:0] t,
   input  word_t      in_data [15:0],
   output word_t      w_t
);

   word_t      sched [16];
   logic [3:0] idx;

   assign idx = t[3:0];

   // Slot t mod 16 still holds W_{t-16}; the expanded word overwrites it.
   always_comb begin
      if (t < 7'd16)
         w_t = sched[idx];
      else
         w_t = rotl(sched[idx - 4'd3] ^ sched[idx - 4'd8] ^
                    sched[idx - 4'd14] ^ sched[idx], 1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < 16; i++)
            sched[i] <= '0;
      end else if (load) begin
         for (int unsigned i = 0; i < 16; i++)
            sched[i] <= in_data[i];
      end else if (advance) begin
         sched[idx] <= w_t;
      end
   end

endmodule

// File: rtl/sha1_block_core.sv
// Single-block SHA-1 compression: one round per clock, digest from the standard IV.
module sha1_block_core
   import sha1_pkg::*;
(
   input  logic  clk,
   input  logic  reset_n,
   input  logic  start,
   input  word_t in_data  [15:0],
   output word_t out_data [4:0],
   output logic  done
);

   state_t     state_q, state_d;
   word_t      a, b, c, d, e;
   word_t      w_t, temp;
   logic [6:0] t_q;
   logic       load, round_en, finish;

   sha1_msg_schedule u_sched (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .advance (round_en),
      .t       (t_q),
      .in_data (in_data),
      .w_t     (w_t)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ROUNDS;
         ROUNDS:  if (t_q == LAST_ROUND) state_d = FINAL;
         FINAL:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load     = 1'b0;
      round_en = 1'b0;
      finish   = 1'b0;
      case (state_q)
         IDLE:    load     = start;
         ROUNDS:  round_en = 1'b1;
         FINAL:   finish   = 1'b1;
         default: ;
      endcase
   end

   assign temp = rotl(a, 5) + f_round(t_q, b, c, d) + e + k_round(t_q) + w_t;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a    <= '0;
         b    <= '0;
         c    <= '0;
         d    <= '0;
         e    <= '0;
         t_q  <= '0;
         done <= 1'b0;
         for (int unsigned i = 0; i < 5; i++)
            out_data[i] <= '0;
      end else if (load) begin
         a    <= IV[0];
         b    <= IV[1];
         c    <= IV[2];
         d    <= IV[3];
         e    <= IV[4];
         t_q  <= '0;
         done <= 1'b0;
      end else if (round_en) begin
         e   <= d;
         d   <= c;
         c   <= rotl(b, 30);
         b   <= a;
         a   <= temp;
         t_q <= t_q + 7'd1;
      end else if (finish) begin
         out_data[0] <= IV[0] + a;
         out_data[1] <= IV[1] + b;
         out_data[2] <= IV[2] + c;
         out_data[3] <= IV[3] + d;
         out_data[4] <= IV[4] + e;
         done        <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sha1_block_core.sv
// Scoreboard bench for sha1_block_core against a plain SHA-1 reference model.
module tb_sha1_block_core;

   localparam logic [159:0] ABC_DIGEST   = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
   localparam logic [159:0] EMPTY_DIGEST = 160'hDA39A3EE_5E6B4B0D_3255BFEF_95601890_AFD80709;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] in_data  [15:0];
   logic [31:0] out_data [4:0];
   logic        done;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;

   typedef struct {
      logic [159:0] digest;
      int           accept_edge;
   } exp_t;

   exp_t sb[$];

   logic [31:0] abc_blk   [16];
   logic [31:0] empty_blk [16];
   logic [31:0] rnd_blk   [16];
   logic [31:0] rnd_blk2  [16];

   sha1_block_core dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .in_data  (in_data),
      .out_data (out_data),
      .done     (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   function automatic logic [159:0] sha1_ref(input logic [31:0] blk [16]);
      logic [31:0] w [80];
      logic [31:0] h [5];
      logic [31:0] a, b, c, d, e, f, k, tmp;
      h[0] = 32'h67452301; h[1] = 32'hEFCDAB89; h[2] = 32'h98BADCFE;
      h[3] = 32'h10325476; h[4] = 32'hC3D2E1F0;
      for (int i = 0; i < 16; i++) w[i] = blk[i];
      for (int i = 16; i < 80; i++) begin
         tmp  = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
         w[i] = {tmp[30:0], tmp[31]};
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
      for (int i = 0; i < 80; i++) begin
         if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
         else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
         else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
         else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
         tmp = {a[26:0], a[31:27]} + f + e + k + w[i];
         e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
      end
      return {h[0] + a, h[1] + b, h[2] + c, h[3] + d, h[4] + e};
   endfunction

   function automatic logic [159:0] digest_now();
      return {out_data[0], out_data[1], out_data[2], out_data[3], out_data[4]};
   endfunction

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every rising done pops one expectation (digest and latency).
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      exp_t x;
      if (done === 1'b1 && prev_done !== 1'b1) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: digest %h at edge %0d, none expected", digest_now(), cycle);
         end else begin
            x = sb.pop_front();
            check("digest", digest_now(), x.digest);
            check("latency", 160'(cycle - x.accept_edge), 160'd81);
         end
      end
      prev_done = done;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] blk [16], input logic [159:0] exp,
                        input bit expect_result, input int hold);
      for (int i = 0; i < 16; i++) in_data[i] = blk[i];
      start = 1'b1;
      if (expect_result) sb.push_back('{exp, cycle + 1});
      repeat (hold) step();
      start = 1'b0;
   endtask

   task automatic wait_empty(input int max_cycles, input bit scramble);
      int n = 0;
      while (sb.size() != 0 && n < max_cycles) begin
         if (scramble)
            for (int i = 0; i < 16; i++) in_data[i] = $urandom;
         step();
         n++;
      end
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: %0d results outstanding after %0d cycles, required 0", sb.size(), max_cycles);
         sb.delete();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         abc_blk[i]   = '0;
         empty_blk[i] = '0;
         in_data[i]   = '0;
      end
      abc_blk[0]   = 32'h61626380;
      abc_blk[15]  = 32'h00000018;
      empty_blk[0] = 32'h80000000;

      repeat (3) step();
      check("reset_done", 160'(done), 160'd0);
      check("reset_out", digest_now(), 160'd0);
      reset_n = 1'b1;
      step();

      // "abc" with a two-cycle start pulse, then the result must hold
      issue(abc_blk, ABC_DIGEST, 1'b1, 2);
      wait_empty(200, 1'b0);
      repeat (3) step();
      check("done_held", 160'(done), 160'd1);
      check("abc_held", digest_now(), ABC_DIGEST);

      // Back-to-back: accept clears done, old digest stays visible
      issue(empty_blk, EMPTY_DIGEST, 1'b1, 1);
      check("done_clear_on_accept", 160'(done), 160'd0);
      check("out_hold_at_accept", digest_now(), ABC_DIGEST);
      repeat (40) step();
      check("out_hold_mid_rounds", digest_now(), ABC_DIGEST);
      wait_empty(200, 1'b0);

      // Start during ROUNDS with another block must be ignored
      issue(abc_blk, ABC_DIGEST, 1'b1, 1);
      repeat (39) step();
      issue(empty_blk, '0, 1'b0, 1);
      wait_empty(200, 1'b0);

      // Reset mid-operation aborts immediately
      issue(abc_blk, ABC_DIGEST, 1'b1, 1);
      repeat (49) step();
      reset_n = 1'b0;
      #1;
      check("abort_done", 160'(done), 160'd0);
      check("abort_out", digest_now(), 160'd0);
      sb.delete();
      repeat (2) step();
      reset_n = 1'b1;
      step();
      issue(abc_blk, ABC_DIGEST, 1'b1, 1);
      wait_empty(200, 1'b0);

      // in_data scrambled every cycle after acceptance
      for (int i = 0; i < 16; i++) rnd_blk[i] = $urandom;
      issue(rnd_blk, sha1_ref(rnd_blk), 1'b1, 1);
      wait_empty(200, 1'b1);

      // start held high across completion starts a second hash on the next IDLE edge
      for (int i = 0; i < 16; i++) begin
         rnd_blk[i]  = $urandom;
         rnd_blk2[i] = $urandom;
         in_data[i]  = rnd_blk[i];
      end
      start = 1'b1;
      sb.push_back('{sha1_ref(rnd_blk), cycle + 1});
      sb.push_back('{sha1_ref(rnd_blk2), cycle + 1 + 82});
      step();
      for (int i = 0; i < 16; i++) in_data[i] = rnd_blk2[i];
      for (int n = 0; n < 200 && sb.size() > 1; n++) step();
      step();
      start = 1'b0;
      wait_empty(200, 1'b0);

      // Randomized blocks
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 16; i++) rnd_blk[i] = $urandom;
         issue(rnd_blk, sha1_ref(rnd_blk), 1'b1, 1 + int'($urandom_range(2)));
         wait_empty(200, 1'b0);
      end

      repeat (2) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
